// File: rtl/button_debouncer_pkg.sv
// Shared types and constants for the button debouncer: FSM state encoding,
// the default debounce length and a helper mapping a level to its idle state.
package button_debouncer_pkg;

    localparam int DEFAULT_DEBOUNCE_CYCLES = 120000;

    typedef enum logic [1:0] {
        STABLE_LO = 2'd0,
        WAIT_HI   = 2'd1,
        STABLE_HI = 2'd2,
        WAIT_LO   = 2'd3
    } state_e;

    function automatic state_e stable_state(input logic level);
        return level ? STABLE_HI : STABLE_LO;
    endfunction

endpackage : button_debouncer_pkg

// File: rtl/sync_2ff.sv
// Two-flop synchronizer bringing an asynchronous input into the clk domain;
// both flops load RESET_VALUE on a synchronous active-high reset.
module sync_2ff #(
    parameter logic RESET_VALUE = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic s1_q;
    logic s2_q;

    // NOTE: clocked state uses non-blocking assignments so every flop samples
    // pre-edge values; blocking here would collapse the two stages into one.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_q <= RESET_VALUE;
            s2_q <= RESET_VALUE;
        end else begin
            s1_q <= d;
            s2_q <= s1_q;
        end
    end

    assign q = s2_q;

endmodule : sync_2ff

// File: rtl/button_debouncer.sv
// Debounces a raw button/switch input into a registered level with optional
// one-cycle rise/fall pulses (enabled by defining BUTTON_DEBOUNCER_EDGE_EN).
module button_debouncer
    import button_debouncer_pkg::*;
#(
    parameter int   DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter logic RESET_LEVEL     = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic pin,
    output logic dout,
    output logic rise,
    output logic fall
);

    localparam int              CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             s2;
    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             dout_q, dout_d;

    sync_2ff #(
        .RESET_VALUE(RESET_LEVEL)
    ) u_sync (
        .clk(clk),
        .rst(rst),
        .d  (pin),
        .q  (s2)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= stable_state(RESET_LEVEL);
            cnt_q   <= '0;
            dout_q  <= RESET_LEVEL;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dout_q  <= dout_d;
        end
    end

    // NOTE: every signal driven here gets a default first, so no path through
    // the case can leave one unassigned and infer a latch.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        dout_d  = dout_q;
        unique case (state_q)
            STABLE_LO: begin
                if (s2) begin
                    state_d = WAIT_HI;
                    cnt_d   = CNT_ONE;
                end
            end
            WAIT_HI: begin
                if (!s2) begin
                    state_d = STABLE_LO;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = STABLE_HI;
                    cnt_d   = '0;
                    dout_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            STABLE_HI: begin
                if (!s2) begin
                    state_d = WAIT_LO;
                    cnt_d   = CNT_ONE;
                end
            end
            WAIT_LO: begin
                if (s2) begin
                    state_d = STABLE_HI;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = STABLE_LO;
                    cnt_d   = '0;
                    dout_d  = 1'b0;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d = stable_state(dout_q);
                cnt_d   = '0;
            end
        endcase
    end

    assign dout = dout_q;

`ifdef BUTTON_DEBOUNCER_EDGE_EN
    logic rise_q;
    logic fall_q;

    // Pulses are computed from the level being loaded, so they line up with dout.
    always_ff @(posedge clk) begin
        if (rst) begin
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            rise_q <= dout_d & ~dout_q;
            fall_q <= ~dout_d & dout_q;
        end
    end

    assign rise = rise_q;
    assign fall = fall_q;
`else
    assign rise = 1'b0;
    assign fall = 1'b0;
`endif

endmodule : button_debouncer

// File: tb/tb_button_debouncer.sv
// Directed self-checking bench: two debouncer instances (reset level 0 and 1)
// with DEBOUNCE_CYCLES=4; pulse expectations follow BUTTON_DEBOUNCER_EDGE_EN.
module tb_button_debouncer;
    import button_debouncer_pkg::*;

`ifdef BUTTON_DEBOUNCER_EDGE_EN
    localparam bit EDGE_EN = 1'b1;
`else
    localparam bit EDGE_EN = 1'b0;
`endif

    logic clk;
    logic rst;
    logic pin0, pin1;
    logic dout0, rise0, fall0;
    logic dout1, rise1, fall1;

    int errors = 0;
    int checks = 0;

    button_debouncer #(.DEBOUNCE_CYCLES(4), .RESET_LEVEL(1'b0)) dut0 (
        .clk(clk), .rst(rst), .pin(pin0), .dout(dout0), .rise(rise0), .fall(fall0)
    );

    button_debouncer #(.DEBOUNCE_CYCLES(4), .RESET_LEVEL(1'b1)) dut1 (
        .clk(clk), .rst(rst), .pin(pin1), .dout(dout1), .rise(rise1), .fall(fall1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge and settle just past it before sampling.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        pin0 = 1'b0;
        pin1 = 1'b1;
        do_reset();
        checks++;
        if (dout0 !== 1'b0) begin errors++; $display("FAIL reset_dout0: got %0b expected 0", dout0); end
        checks++;
        if (rise0 !== 1'b0 || fall0 !== 1'b0) begin errors++; $display("FAIL reset_pulses0: got rise=%0b fall=%0b expected 0/0", rise0, fall0); end
        checks++;
        if (dut0.state_q !== STABLE_LO) begin errors++; $display("FAIL reset_state0: got %0d expected %0d", dut0.state_q, STABLE_LO); end
        checks++;
        if (dut0.cnt_q !== 3'd0) begin errors++; $display("FAIL reset_cnt0: got %0d expected 0", dut0.cnt_q); end
        checks++;
        if (dout1 !== 1'b1) begin errors++; $display("FAIL reset_dout1: got %0b expected 1", dout1); end
        checks++;
        if (dut1.state_q !== STABLE_HI) begin errors++; $display("FAIL reset_state1: got %0d expected %0d", dut1.state_q, STABLE_HI); end
        checks++;
        if (rise1 !== 1'b0 || fall1 !== 1'b0) begin errors++; $display("FAIL reset_pulses1: got rise=%0b fall=%0b expected 0/0", rise1, fall1); end
    endtask

    // Clean 0->1 then 1->0 step on dut0: level changes at edge 6 of each step.
    task automatic test_clean_step();
        logic exp_d, exp_r, exp_f;
        pin0 = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            tick();
            exp_d = (k >= 6);
            exp_r = EDGE_EN && (k == 6);
            checks++;
            if (dout0 !== exp_d) begin errors++; $display("FAIL step_up_dout edge %0d: got %0b expected %0b", k, dout0, exp_d); end
            checks++;
            if (rise0 !== exp_r || fall0 !== 1'b0) begin errors++; $display("FAIL step_up_pulses edge %0d: got rise=%0b fall=%0b expected %0b/0", k, rise0, fall0, exp_r); end
        end
        pin0 = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            tick();
            exp_d = (k < 6);
            exp_f = EDGE_EN && (k == 6);
            checks++;
            if (dout0 !== exp_d) begin errors++; $display("FAIL step_dn_dout edge %0d: got %0b expected %0b", k, dout0, exp_d); end
            checks++;
            if (fall0 !== exp_f || rise0 !== 1'b0) begin errors++; $display("FAIL step_dn_pulses edge %0d: got rise=%0b fall=%0b expected 0/%0b", k, rise0, fall0, exp_f); end
        end
    endtask

    // Pin high for 3 cycles only: one sample short of acceptance.
    task automatic test_glitch();
        for (int k = 0; k < 10; k++) begin
            pin0 = (k < 3);
            tick();
            checks++;
            if (dout0 !== 1'b0 || rise0 !== 1'b0 || fall0 !== 1'b0) begin
                errors++;
                $display("FAIL glitch edge %0d: got dout=%0b rise=%0b fall=%0b expected 0/0/0", k + 1, dout0, rise0, fall0);
            end
        end
        checks++;
        if (dut0.state_q !== STABLE_LO) begin errors++; $display("FAIL glitch_state: got %0d expected %0d", dut0.state_q, STABLE_LO); end
        checks++;
        if (dut0.cnt_q !== 3'd0) begin errors++; $display("FAIL glitch_cnt: got %0d expected 0", dut0.cnt_q); end
    endtask

    // Pattern 1,0,1,1,0 then 1 held; final rise first sampled at edge 6,
    // so dout goes high at edge 11.
    task automatic test_bounce();
        logic [4:0] pattern;
        logic exp_d, exp_r;
        int rises;
        pattern = 5'b01101;
        rises = 0;
        for (int k = 0; k < 15; k++) begin
            pin0 = (k < 5) ? pattern[k] : 1'b1;
            tick();
            exp_d = (k + 1 >= 11);
            exp_r = EDGE_EN && (k + 1 == 11);
            if (rise0 === 1'b1) rises++;
            checks++;
            if (dout0 !== exp_d) begin errors++; $display("FAIL bounce_dout edge %0d: got %0b expected %0b", k + 1, dout0, exp_d); end
            checks++;
            if (rise0 !== exp_r || fall0 !== 1'b0) begin errors++; $display("FAIL bounce_pulses edge %0d: got rise=%0b fall=%0b expected %0b/0", k + 1, rise0, fall0, exp_r); end
        end
        checks++;
        if (rises != (EDGE_EN ? 1 : 0)) begin errors++; $display("FAIL bounce_rise_count: got %0d expected %0d", rises, EDGE_EN ? 1 : 0); end
        pin0 = 1'b0;
        do_reset();
    endtask

    task automatic test_reset_mid_wait();
        logic exp_d, exp_r;
        pin0 = 1'b1;
        for (int k = 1; k <= 4; k++) tick();
        checks++;
        if (dut0.state_q !== WAIT_HI || dut0.cnt_q !== 3'd2) begin
            errors++;
            $display("FAIL midwait_pre: got state=%0d cnt=%0d expected %0d/2", dut0.state_q, dut0.cnt_q, WAIT_HI);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if (dout0 !== 1'b0 || dut0.cnt_q !== 3'd0 || rise0 !== 1'b0 || fall0 !== 1'b0 || dut0.state_q !== STABLE_LO) begin
            errors++;
            $display("FAIL midwait_abort: got dout=%0b cnt=%0d rise=%0b fall=%0b state=%0d expected 0/0/0/0/%0d",
                     dout0, dut0.cnt_q, rise0, fall0, dut0.state_q, STABLE_LO);
        end
        for (int k = 1; k <= 8; k++) begin
            tick();
            exp_d = (k >= 6);
            exp_r = EDGE_EN && (k == 6);
            checks++;
            if (dout0 !== exp_d) begin errors++; $display("FAIL midwait_dout edge %0d: got %0b expected %0b", k, dout0, exp_d); end
            checks++;
            if (rise0 !== exp_r || fall0 !== 1'b0) begin errors++; $display("FAIL midwait_pulses edge %0d: got rise=%0b fall=%0b expected %0b/0", k, rise0, fall0, exp_r); end
        end
    endtask

    // dut1 idles high: hold pin low then high again, checking fall then rise.
    task automatic test_reset_level_one();
        logic exp_d, exp_p;
        pin1 = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            tick();
            exp_d = (k < 6);
            exp_p = EDGE_EN && (k == 6);
            checks++;
            if (dout1 !== exp_d) begin errors++; $display("FAIL lvl1_dn_dout edge %0d: got %0b expected %0b", k, dout1, exp_d); end
            checks++;
            if (fall1 !== exp_p || rise1 !== 1'b0) begin errors++; $display("FAIL lvl1_dn_pulses edge %0d: got rise=%0b fall=%0b expected 0/%0b", k, rise1, fall1, exp_p); end
        end
        pin1 = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            tick();
            exp_d = (k >= 6);
            exp_p = EDGE_EN && (k == 6);
            checks++;
            if (dout1 !== exp_d) begin errors++; $display("FAIL lvl1_up_dout edge %0d: got %0b expected %0b", k, dout1, exp_d); end
            checks++;
            if (rise1 !== exp_p || fall1 !== 1'b0) begin errors++; $display("FAIL lvl1_up_pulses edge %0d: got rise=%0b fall=%0b expected %0b/0", k, rise1, fall1, exp_p); end
        end
    endtask

    initial begin
        rst  = 1'b1;
        pin0 = 1'b0;
        pin1 = 1'b1;
        test_reset();
        test_clean_step();
        test_glitch();
        test_bounce();
        test_reset_mid_wait();
        test_reset_level_one();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got no completion expected finish before 100000 ns");
        $fatal(1, "timeout");
    end

endmodule : tb_button_debouncer

// File: doc/button_debouncer.md
BUTTON_DEBOUNCER -- requirements
Module: button_debouncer

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 120000, which sets the number of consecutive stable synchronized samples needed to accept a new level (legal range 2..2^24).
REQ-002 SHALL have parameter RESET_LEVEL, default 1'b0, which sets the debounced level loaded at reset.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all logic on the rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 SHALL have port pin, input, 1 bit: raw asynchronous button or switch input.
REQ-006 SHALL have port dout, output, 1 bit: debounced level, registered; this output feeds the downstream NOT/OR logic.
REQ-007 SHALL have port rise, output, 1 bit: one-cycle pulse when dout goes 0->1.
REQ-008 SHALL have port fall, output, 1 bit: one-cycle pulse when dout goes 1->0.

Function
REQ-009 SHALL pass pin through a 2-flop synchronizer; the second-flop value (s2) is the only value the debouncing logic uses.
REQ-010 SHALL implement four FSM states: STABLE_LO, WAIT_HI, STABLE_HI, WAIT_LO.
REQ-011 In STABLE_x, s2 differing from dout SHALL cause entry to the matching WAIT state with cnt=1.
REQ-012 In WAIT_x, s2 equal to the candidate level SHALL increment cnt; s2 reverting SHALL return to STABLE_x with cnt=0 and dout unchanged.
REQ-013 In WAIT_x, when cnt==DEBOUNCE_CYCLES-1 and s2 still equals the candidate, the FSM SHALL move to the opposite STABLE state, update dout and clear cnt in the same edge.
REQ-014 For a clean step first sampled at edge 1, dout SHALL change at edge DEBOUNCE_CYCLES+2, no earlier and no later.
REQ-015 Any input pulse shorter than DEBOUNCE_CYCLES synchronized samples SHALL leave dout unchanged.
REQ-016 rise/fall SHALL assert in exactly the cycle dout takes its new value and SHALL deassert the following cycle; rise and fall SHALL never both be 1.
REQ-017 The counter SHALL be $clog2(DEBOUNCE_CYCLES+1) bits wide and SHALL never wrap; it saturates only through the REQ-013 transition.

Reset
REQ-018 On rst=1 at a clock edge, both sync flops and dout SHALL load RESET_LEVEL, the FSM SHALL load STABLE_LO or STABLE_HI per RESET_LEVEL, and cnt, rise and fall SHALL load 0.
REQ-019 rst asserted mid-WAIT SHALL abort the pending transition with no rise/fall pulse; rst has priority over every other event.

Configuration
REQ-020 Macro BUTTON_DEBOUNCER_EDGE_EN defined SHALL compile the rise/fall pulse registers in.
REQ-021 Macro BUTTON_DEBOUNCER_EDGE_EN undefined SHALL keep the rise and fall ports but drive them constant 0, with no edge registers synthesized; dout behaviour is identical in both builds.

Structure
REQ-022 Package button_debouncer_pkg SHALL hold the FSM state typedef (2-bit enum) and the default-cycle constant.
REQ-023 The synchronizer SHALL be a separate sub-module, sync_2ff, with ports clk, rst, d, q and a reset-value parameter.

Verification (DEBOUNCE_CYCLES=4, RESET_LEVEL=0 unless stated)
REQ-024 Clean step: pin 0->1 held -> dout=1 at edge 6, rise=1 for that cycle only, fall=0 throughout.
REQ-025 Glitch: pin high for 3 cycles then low -> dout stays 0, rise never asserts, FSM back in STABLE_LO.
REQ-026 Bounce: pin toggles 1,0,1,1,0 then holds 1 -> dout=1 exactly 4 stable s2 samples after the final rise; exactly one rise pulse.
REQ-027 Reset mid-WAIT: rst=1 for 1 cycle while cnt=2 -> dout=0, cnt=0, no pulse; pin still high -> dout=1 at 6 edges after rst release.
REQ-028 RESET_LEVEL=1: after reset dout=1; pin low held -> fall pulse at edge 6; with macro undefined, rise=fall=0 always and dout timing unchanged.
